// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - push/pop handshake and RAM port bundle for ram_fifo_ctrl
//
// Purpose: groups every non-clock/reset signal of ram_fifo_ctrl.
//   slave  modport : the controller itself.
//   master modport : the surrounding logic (push source, pop sink and the RAM).
// Signals:
//   wr_valid/wr_data/wr_ready : push port
//   rd_valid/rd_data/rd_ready : pop port (rd_data is the FIFO head)
//   count/full/empty          : occupancy status
//   ram_we/ram_addr/ram_wdata : controller -> single-port RAM
//   ram_rdata                 : RAM -> controller, registered one cycle after addr
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_rdata,
    output wr_ready, rd_valid, rd_data, count, full, empty,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_rdata,
    input  wr_ready, rd_valid, rd_data, count, full, empty,
    input  ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller in front of a single-port synchronous RAM
//
// Purpose: turns a single-port RAM (shared address, write on posedge when we=1,
// read data registered one cycle after the address) into a FIFO with
// valid/ready push and pop ports. One RAM access per cycle; a pending read
// always wins the port over a write. Read data lands in a one-entry output
// register that drives the pop port.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : ram_fifo_ctrl_if.slave (push, pop, status and RAM port signals)
// Parameters:
//   DATA_WIDTH : word width, must match the RAM
//   ADDR_WIDTH : RAM address width
//   MEM_DEPTH  : RAM words in use, 3 <= MEM_DEPTH <= 2**ADDR_WIDTH (any value)
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_DEPTH  = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(MEM_DEPTH - 1);

  // IDLE: no read outstanding. RD_WAIT: read issued last cycle, RAM data
  // becomes valid this cycle.
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

  logic full;
  logic rd_issue;
  logic wr_ready;
  logic wr_fire;
  logic pop;

  // Pointers wrap explicitly so MEM_DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // A read is only launched when the output register is free and no read is
  // already in flight, so at most one word is ever between RAM and rd_data.
  assign full     = (mem_count_q == DEPTH_CNT);
  assign rd_issue = (state_q == IDLE) && !out_valid_q && (mem_count_q != '0);
  assign wr_ready = !full && !rd_issue;
  assign wr_fire  = bus.wr_valid && wr_ready;
  assign pop      = out_valid_q && bus.rd_ready;

  // RAM port: address follows the read pointer only in the issue cycle; the
  // write pointer and write data are presented otherwise, gated by ram_we.
  assign bus.ram_we    = wr_fire;
  assign bus.ram_addr  = rd_issue ? rd_ptr_q : wr_ptr_q;
  assign bus.ram_wdata = bus.wr_data;

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = out_valid_q;
  assign bus.rd_data  = out_data_q;
  assign bus.full     = full;
  assign bus.count    = mem_count_q
                      + (ADDR_WIDTH+1)'(state_q == RD_WAIT)
                      + (ADDR_WIDTH+1)'(out_valid_q);
  assign bus.empty    = (bus.count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // Read issue and write are mutually exclusive (wr_ready excludes
    // rd_issue), so mem_count never sees an increment and decrement together.
    if (wr_fire) begin
      wr_ptr_d    = ptr_inc(wr_ptr_q);
      mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(1);
    end

    // Consuming the head just empties the register; rd_data keeps the old
    // word until the next capture.
    if (pop) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_issue) begin
          rd_ptr_d    = ptr_inc(rd_ptr_q);
          mem_count_d = mem_count_q - (ADDR_WIDTH+1)'(1);
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // out_valid is necessarily 0 here (issue required it), so capture
        // cannot collide with a pop.
        out_data_d  = bus.ram_rdata;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard testbench for ram_fifo_ctrl with a behavioural RAM
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic clk;
  logic rst_n;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single-port RAM: write on posedge, read data registered one cycle later.
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid && bus.rd_ready) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h with empty scoreboard at %0t", bus.rd_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", bus.rd_data, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents d with wr_valid high until accepted; records it on acceptance.
  task automatic push_word(input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        exp_q.push_back(d);
        done = 1'b1;
      end
      tick();
    end
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && bus.empty) done = 1'b1;
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int cyc;
    int base;
    logic [AW-1:0] arb_addr [6];
    logic          arb_rdy  [6];

    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    #2;
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_ram_we",   32'(bus.ram_we),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous mid-cycle reset with two words held.
    push_word(8'h01);
    push_word(8'h02);
    bus.wr_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
    chk("pre_rst_count", 32'(bus.count),    32'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("arst_count",    32'(bus.count),    32'd0);
    chk("arst_empty",    32'(bus.empty),    32'd1);
    chk("arst_full",     32'(bus.full),     32'd0);
    chk("arst_ram_we",   32'(bus.ram_we),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word 0xA5: write at addr 0, issue next cycle, rd_valid two after issue.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    @(negedge clk);
    chk("sw_we",      32'(bus.ram_we),   32'd1);
    chk("sw_waddr",   32'(bus.ram_addr), 32'd0);
    chk("sw_wready",  32'(bus.wr_ready), 32'd1);
    if (bus.wr_ready) exp_q.push_back(8'hA5);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    chk("sw_issue_we",    32'(bus.ram_we),   32'd0);
    chk("sw_issue_addr",  32'(bus.ram_addr), 32'd0);
    chk("sw_issue_wrdy",  32'(bus.wr_ready), 32'd0);
    chk("sw_issue_count", 32'(bus.count),    32'd1);
    tick();
    @(negedge clk);
    chk("sw_wait_valid",  32'(bus.rd_valid), 32'd0);
    chk("sw_wait_count",  32'(bus.count),    32'd1);
    tick();
    @(negedge clk);
    chk("sw_valid",       32'(bus.rd_valid), 32'd1);
    chk("sw_data",        32'(bus.rd_data),  32'hA5);
    tick();
    @(negedge clk);
    chk("sw_popped_empty", 32'(bus.empty),    32'd1);
    chk("sw_popped_valid", 32'(bus.rd_valid), 32'd0);
    chk("sw_data_held",    32'(bus.rd_data),  32'hA5);
    tick();

    // Arbitration with wr_valid held and rd_ready=1; pointers start at 1.
    arb_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    arb_addr = '{7'd1, 7'd1, 7'd2, 7'd3, 7'd2, 7'd4};
    w = 0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'(8'h50 + w);
      @(negedge clk);
      chk($sformatf("arb_wready_%0d", i), 32'(bus.wr_ready), 32'(arb_rdy[i]));
      chk($sformatf("arb_we_%0d", i),     32'(bus.ram_we),   32'(arb_rdy[i]));
      chk($sformatf("arb_addr_%0d", i),   32'(bus.ram_addr), 32'(arb_addr[i]));
      if (bus.wr_ready) begin
        exp_q.push_back(bus.wr_data);
        w++;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("arb_accepted", 32'(w), 32'd4);
    drain(100);

    // Fill from a clean reset with rd_ready=0.
    bus.rd_ready = 1'b0;
    do_reset();
    for (int k = 0; k <= 128; k++) push_word(8'(k));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd129;
    @(negedge clk);
    chk("fill_full",   32'(bus.full),     32'd1);
    chk("fill_wready", 32'(bus.wr_ready), 32'd0);
    chk("fill_we",     32'(bus.ram_we),   32'd0);
    chk("fill_count",  32'(bus.count),    32'd129);
    tick();
    bus.rd_ready = 1'b1;
    @(negedge clk);
    chk("fill_pop_full", 32'(bus.full), 32'd1);
    tick();
    bus.rd_ready = 1'b0;
    @(negedge clk);
    chk("fill_issue_wready", 32'(bus.wr_ready), 32'd0);
    chk("fill_issue_addr",   32'(bus.ram_addr), 32'd1);
    tick();
    @(negedge clk);
    chk("fill_free_full",   32'(bus.full),     32'd0);
    chk("fill_free_wready", 32'(bus.wr_ready), 32'd1);
    chk("fill_free_we",     32'(bus.ram_we),   32'd1);
    chk("fill_free_addr",   32'(bus.ram_addr), 32'd1);
    chk("fill_free_count",  32'(bus.count),    32'd128);
    if (bus.wr_ready) exp_q.push_back(8'd129);
    tick();
    drain(1000);

    // 300-word stream with random valid/ready; pointers wrap more than twice.
    base = pops;
    w = 0;
    cyc = 0;
    while (w < 300 && cyc < 6000) begin
      bus.rd_ready = 1'($urandom_range(0, 1));
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_data  = 8'(w);
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) begin
        exp_q.push_back(8'(w));
        w++;
      end
      tick();
      cyc++;
    end
    chk("stream_pushed", 32'(w), 32'd300);
    drain(2000);
    chk("stream_popped", 32'(pops - base), 32'd300);

    // Reset in the RD_WAIT cycle, then push 0x3C.
    bus.rd_ready = 1'b0;
    push_word(8'h11);
    bus.wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rw_wait_count", 32'(bus.count),    32'd1);
    chk("rw_wait_valid", 32'(bus.rd_valid), 32'd0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rw_rst_count", 32'(bus.count),    32'd0);
    chk("rw_rst_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rw_after_count", 32'(bus.count),    32'd0);
    chk("rw_after_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    base = pops;
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h3C;
    @(negedge clk);
    chk("rw_waddr", 32'(bus.ram_addr), 32'd0);
    chk("rw_we",    32'(bus.ram_we),   32'd1);
    if (bus.wr_ready) exp_q.push_back(8'h3C);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("rw_raddr", 32'(bus.ram_addr), 32'd0);
    chk("rw_rwe",   32'(bus.ram_we),   32'd0);
    tick();
    drain(50);
    chk("rw_popped", 32'(pops - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
